// File: rtl/serial_frame_pkg.sv
// Shared frame layout for the BEP thermostat serial link (encoder and receiver).
package serial_frame_pkg;

    localparam int FRAME_BITS = 192;
    localparam logic [31:0] DEFAULT_PREAMBLE = 32'hAAAA_AAAA;

    localparam int PREAMBLE_MSB      = 191;
    localparam int PREAMBLE_LSB      = 160;
    localparam int TYPE_1_MSB        = 159;
    localparam int TYPE_1_LSB        = 144;
    localparam int TYPE_2_MSB        = 143;
    localparam int TYPE_2_LSB        = 128;
    localparam int CONSTANT_MSB      = 127;
    localparam int CONSTANT_LSB      = 96;
    localparam int THERMOSTAT_ID_MSB = 95;
    localparam int THERMOSTAT_ID_LSB = 64;
    localparam int ROOM_TEMP_MSB     = 63;
    localparam int ROOM_TEMP_LSB     = 48;
    localparam int SET_TEMP_MSB      = 47;
    localparam int SET_TEMP_LSB      = 32;
    localparam int STATE_MSB         = 31;
    localparam int STATE_LSB         = 24;
    localparam int TAIL_1_MSB        = 23;
    localparam int TAIL_1_LSB        = 16;
    localparam int TAIL_2_MSB        = 15;
    localparam int TAIL_2_LSB        = 8;
    localparam int TAIL_3_MSB        = 7;
    localparam int TAIL_3_LSB        = 0;

    localparam int SUM_BYTES = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } frame_state_t;

    // Modulo-256 sum of the 19 bytes between the preamble and tail_3.
    function automatic logic [7:0] byte_sum(input logic [SUM_BYTES*8-1:0] bytes);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < SUM_BYTES; i++) begin
            s = s + bytes[i*8 +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/serial_bit_clock_gen.sv
// Divides clk into serial_clock; strobes mark the clk edge on which serial_clock rises/falls.
module serial_bit_clock_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic serial_clock,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = $clog2(HALF_PERIOD) + 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(HALF_PERIOD - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    assign tc   = run && (div_cnt == DIV_TC);
    assign rise = tc && !serial_clock;
    assign fall = tc && serial_clock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            serial_clock <= 1'b0;
        end else if (!run) begin
            div_cnt      <= '0;
            serial_clock <= 1'b0;
        end else if (tc) begin
            div_cnt      <= '0;
            serial_clock <= !serial_clock;
        end else begin
            div_cnt      <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_encode.sv
// BEP thermostat frame transmitter: 192-bit frame, MSB first, data launched on serial_clock falls.
// Build option SERIAL_ENCODE_CKSUM_EN replaces tail_3 with the byte sum of frame bits 159:8.
//
// state | meaning
// IDLE  | frame_ready high, waiting for frame_valid
// SHIFT | clocking out the 192 frame bits
// GAP   | quiet time before the next frame is accepted
module serial_encode
    import serial_frame_pkg::*;
#(
    parameter int          HALF_PERIOD = 4,
    parameter int          GAP_CYCLES  = 16,
    parameter logic [31:0] PREAMBLE    = DEFAULT_PREAMBLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [15:0] type_1,
    input  logic [15:0] type_2,
    input  logic [31:0] constant,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        serial_clock,
    output logic        serial_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

    frame_state_t          cur_state;
    frame_state_t          nxt_state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] load_word;
    logic [7:0]            tail_byte;
    logic [7:0]            bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  ready_en;
    logic                  accept;
    logic                  last_fall;
    logic                  bit_fall;
    logic                  bit_rise_unused;

`ifdef SERIAL_ENCODE_CKSUM_EN
    logic unused_tail_3;
    assign unused_tail_3 = ^tail_3;
    assign tail_byte = byte_sum({type_1, type_2, constant, thermostat_id,
                                 room_temp, set_temp, state, tail_1, tail_2});
`else
    assign tail_byte = tail_3;
`endif

    assign load_word = {PREAMBLE, type_1, type_2, constant, thermostat_id,
                        room_temp, set_temp, state, tail_1, tail_2, tail_byte};

    serial_bit_clock_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_bit_clock (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (cur_state == SHIFT),
        .serial_clock(serial_clock),
        .rise        (bit_rise_unused),
        .fall        (bit_fall)
    );

    // ready_en keeps frame_ready low until the first edge after reset release.
    assign frame_ready = ready_en && (cur_state == IDLE);
    assign accept      = frame_valid && frame_ready;
    assign last_fall   = bit_fall && (bit_cnt == LAST_BIT);
    assign busy        = (cur_state != IDLE);
    assign serial_data = (cur_state == SHIFT) && shift_reg[FRAME_BITS-1];

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (accept) nxt_state = SHIFT;
            SHIFT:   if (last_fall) nxt_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == '0) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            ready_en   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            ready_en   <= 1'b1;
            frame_done <= (cur_state != IDLE) && (nxt_state == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            if (accept) begin
                shift_reg <= load_word;
                bit_cnt   <= '0;
            end else if ((cur_state == SHIFT) && bit_fall) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (last_fall) begin
                gap_cnt <= GAP_LOAD;
            end else if ((cur_state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_encode.sv
// Bench for serial_encode: two instances (HALF_PERIOD=2/GAP=4 and HALF_PERIOD=1/GAP=0) with a bit-level receiver.
module tb_serial_encode;

    localparam int HP_A = 2;
    localparam int GAP_A = 4;
    localparam int HP_B = 1;
    localparam int GAP_B = 0;
    localparam int LEN_A = 384 * HP_A + GAP_A;
    localparam int LEN_B = 384 * HP_B + GAP_B;

    typedef struct {
        logic [15:0] t1;
        logic [15:0] t2;
        logic [31:0] cst;
        logic [31:0] tid;
        logic [15:0] room;
        logic [15:0] setp;
        logic [7:0]  st;
        logic [7:0]  tl1;
        logic [7:0]  tl2;
        logic [7:0]  tl3;
    } fields_t;

    typedef struct {
        fields_t      f;
        bit           sel;
        logic [191:0] exp_frame;
        int           exp_cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_a, valid_b;
    logic [15:0] type_1, type_2, room_temp, set_temp;
    logic [31:0] constant, thermostat_id;
    logic [7:0]  state, tail_1, tail_2, tail_3;
    logic ready_a, sclk_a, sdata_a, busy_a, done_a;
    logic ready_b, sclk_b, sdata_b, busy_b, done_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_encode #(.HALF_PERIOD(HP_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_valid(valid_a), .frame_ready(ready_a),
        .type_1(type_1), .type_2(type_2), .constant(constant), .thermostat_id(thermostat_id),
        .room_temp(room_temp), .set_temp(set_temp), .state(state),
        .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3),
        .serial_clock(sclk_a), .serial_data(sdata_a), .busy(busy_a), .frame_done(done_a)
    );

    serial_encode #(.HALF_PERIOD(HP_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_valid(valid_b), .frame_ready(ready_b),
        .type_1(type_1), .type_2(type_2), .constant(constant), .thermostat_id(thermostat_id),
        .room_temp(room_temp), .set_temp(set_temp), .state(state),
        .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3),
        .serial_clock(sclk_b), .serial_data(sdata_b), .busy(busy_b), .frame_done(done_b)
    );

    // Receiver: sample serial_data on serial_clock rise, 192 bits per frame.
    logic [191:0] sh_a, sh_b;
    logic [191:0] rx_a [0:15];
    logic [191:0] rx_b [0:15];
    int bits_a = 0, rise_a = 0, rxn_a = 0;
    int bits_b = 0, rise_b = 0, rxn_b = 0;

    always @(posedge sclk_a or negedge rst_n) begin
        if (!rst_n) begin
            bits_a <= 0;
        end else begin
            rise_a <= rise_a + 1;
            sh_a   <= {sh_a[190:0], sdata_a};
            if (bits_a == 191) begin
                rx_a[rxn_a[3:0]] <= {sh_a[190:0], sdata_a};
                rxn_a  <= rxn_a + 1;
                bits_a <= 0;
            end else begin
                bits_a <= bits_a + 1;
            end
        end
    end

    always @(posedge sclk_b or negedge rst_n) begin
        if (!rst_n) begin
            bits_b <= 0;
        end else begin
            rise_b <= rise_b + 1;
            sh_b   <= {sh_b[190:0], sdata_b};
            if (bits_b == 191) begin
                rx_b[rxn_b[3:0]] <= {sh_b[190:0], sdata_b};
                rxn_b  <= rxn_b + 1;
                bits_b <= 0;
            end else begin
                bits_b <= bits_b + 1;
            end
        end
    end

    // Length of the busy, serial_clock-low run that ends when busy drops (the gap).
    int run_a = 0, last_run_a = 0, done_cnt_a = 0;
    always @(negedge clk) begin
        if (busy_a && !sclk_a) begin
            run_a <= run_a + 1;
        end else begin
            last_run_a <= run_a;
            run_a      <= 0;
        end
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    // serial_data may only change together with a serial_clock fall while a frame is on the wire.
    logic psclk_b = 1'b0, psdata_b = 1'b0, pbusy_b = 1'b0;
    int tchk = 0, tviol = 0;
    always @(negedge clk) begin
        if (busy_b && pbusy_b) begin
            if (sclk_b && !psclk_b) begin
                tchk <= tchk + 1;
                if (sdata_b !== psdata_b) tviol <= tviol + 1;
            end else if (sdata_b !== psdata_b) begin
                tchk <= tchk + 1;
                if (!(psclk_b && !sclk_b)) tviol <= tviol + 1;
            end
        end
        psclk_b  <= sclk_b;
        psdata_b <= sdata_b;
        pbusy_b  <= busy_b;
    end

    logic [191:0] exp_qa [$];
    logic [191:0] exp_qb [$];
    int rd_a = 0, rd_b = 0;
    logic [191:0] last_rx;

    task automatic chk_i(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic chk_v(input string name, input logic [191:0] act, input logic [191:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic fields_t mk(input logic [15:0] t1, input logic [15:0] t2,
                                   input logic [31:0] cst, input logic [31:0] tid,
                                   input logic [15:0] room, input logic [15:0] setp,
                                   input logic [7:0] st, input logic [7:0] tl1,
                                   input logic [7:0] tl2, input logic [7:0] tl3);
        fields_t f;
        f.t1 = t1; f.t2 = t2; f.cst = cst; f.tid = tid; f.room = room;
        f.setp = setp; f.st = st; f.tl1 = tl1; f.tl2 = tl2; f.tl3 = tl3;
        return f;
    endfunction

    function automatic logic [191:0] build_frame(input fields_t f);
        logic [7:0] t3;
`ifdef SERIAL_ENCODE_CKSUM_EN
        t3 = f.t1[15:8] + f.t1[7:0] + f.t2[15:8] + f.t2[7:0]
           + f.cst[31:24] + f.cst[23:16] + f.cst[15:8] + f.cst[7:0]
           + f.tid[31:24] + f.tid[23:16] + f.tid[15:8] + f.tid[7:0]
           + f.room[15:8] + f.room[7:0] + f.setp[15:8] + f.setp[7:0]
           + f.st + f.tl1 + f.tl2;
`else
        t3 = f.tl3;
`endif
        return {32'hAAAA_AAAA, f.t1, f.t2, f.cst, f.tid, f.room, f.setp, f.st, f.tl1, f.tl2, t3};
    endfunction

    function automatic int rdy(input bit sel);
        return sel ? {31'b0, ready_b} : {31'b0, ready_a};
    endfunction

    function automatic int bsy(input bit sel);
        return sel ? {31'b0, busy_b} : {31'b0, busy_a};
    endfunction

    function automatic int dn(input bit sel);
        return sel ? {31'b0, done_b} : {31'b0, done_a};
    endfunction

    task automatic drive(input fields_t f);
        type_1 = f.t1; type_2 = f.t2; constant = f.cst; thermostat_id = f.tid;
        room_temp = f.room; set_temp = f.setp; state = f.st;
        tail_1 = f.tl1; tail_2 = f.tl2; tail_3 = f.tl3;
    endtask

    task automatic drive_noise();
        type_1 = 16'($urandom); type_2 = 16'($urandom); constant = $urandom;
        thermostat_id = $urandom; room_temp = 16'($urandom); set_temp = 16'($urandom);
        state = 8'($urandom); tail_1 = 8'($urandom); tail_2 = 8'($urandom); tail_3 = 8'($urandom);
    endtask

    task automatic set_valid(input bit sel, input logic v);
        if (sel) valid_b = v;
        else     valid_a = v;
    endtask

    task automatic wait_ready(input bit sel);
        int w;
        w = 0;
        while (rdy(sel) == 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk_i("accept_ready", rdy(sel), 1);
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        while (dn(sel) == 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_rx(input bit sel);
        logic [191:0] e, g;
        bit have;
        have = 0;
        e = '0;
        g = '0;
        if (!sel) begin
            if (exp_qa.size() > 0 && rxn_a > rd_a) begin
                e = exp_qa.pop_front(); g = rx_a[rd_a[3:0]]; rd_a++; have = 1;
            end
        end else begin
            if (exp_qb.size() > 0 && rxn_b > rd_b) begin
                e = exp_qb.pop_front(); g = rx_b[rd_b[3:0]]; rd_b++; have = 1;
            end
        end
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_frame: dut %0d got no received frame, expected one", sel);
        end else begin
            chk_v("rx_frame", g, e);
            chk_v("rx_preamble", {160'b0, g[191:160]}, {160'b0, 32'hAAAA_AAAA});
            last_rx = g;
        end
    endtask

    task automatic run_frame(input bit sel, input fields_t f, input logic [191:0] exp, input int exp_cyc);
        int cyc, r0;
        @(negedge clk);
        drive(f);
        set_valid(sel, 1'b1);
        wait_ready(sel);
        if (sel) exp_qb.push_back(exp);
        else     exp_qa.push_back(exp);
        r0 = sel ? rise_b : rise_a;
        @(posedge clk);
        #1;
        set_valid(sel, 1'b0);
        drive_noise();
        chk_i("busy_after_accept", bsy(sel), 1);
        wait_done(sel, cyc);
        chk_i("done_latency", cyc, exp_cyc);
        chk_i("rise_count", (sel ? rise_b : rise_a) - r0, 192);
        chk_i("ready_in_done_cycle", rdy(sel), 1);
        @(negedge clk);
        #1;
        if (!sel) chk_i("gap_cycles", last_run_a, GAP_A);
        check_rx(sel);
        @(posedge clk);
        #1;
        chk_i("done_one_cycle", dn(sel), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v [4];
        fields_t f;
        int cyc, d0, n0, t0;

        v[0].f = mk(16'hD391, 16'hD391, 32'h0DFF_FFFF, 32'h1234_5678, 16'h00C8, 16'h00D2,
                    8'h0C, 8'h45, 8'h12, 8'h34);
        v[0].sel = 0;
        v[1].f = mk(16'hFFFF, 16'h0000, 32'h8000_0001, 32'hDEAD_BEEF, 16'h7FFF, 16'h8000,
                    8'hFF, 8'h00, 8'hFF, 8'hA5);
        v[1].sel = 0;
        v[2].f = mk(16'h0123, 16'h4567, 32'h89AB_CDEF, 32'h5555_AAAA, 16'h0F0F, 16'hF0F0,
                    8'h3C, 8'hC3, 8'h81, 8'h7E);
        v[2].sel = 1;
        v[3].f = mk(16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF,
                    8'hFF, 8'hFF, 8'hFF, 8'hFF);
        v[3].sel = 1;
        for (int i = 0; i < 4; i++) begin
            v[i].exp_frame  = build_frame(v[i].f);
            v[i].exp_cycles = v[i].sel ? LEN_B : LEN_A;
        end

        // Reset held with frame_valid high.
        rst_n = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        drive(v[0].f);
        repeat (3) @(negedge clk);
        chk_i("reset_outputs_a", {27'b0, ready_a, busy_a, done_a, sclk_a, sdata_a}, 0);
        chk_i("reset_outputs_b", {27'b0, ready_b, busy_b, done_b, sclk_b, sdata_b}, 0);
        rst_n = 1'b1;
        #1;
        chk_i("ready_before_first_edge", rdy(0), 0);
        @(posedge clk);
        #1;
        chk_i("ready_after_first_edge_a", rdy(0), 1);
        chk_i("ready_after_first_edge_b", rdy(1), 1);
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (2) @(negedge clk);
        chk_i("idle_after_reset", bsy(0), 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(v[i].sel, v[i].f, v[i].exp_frame, v[i].exp_cycles);
        end
        chk_i("timing_violations_hp1", tviol, 0);
        chk_i("timing_checks_seen_hp1", (tchk >= 192) ? 1 : 0, 1);

        // Back-to-back with frame_valid held across both frames.
        @(negedge clk);
        drive(v[1].f);
        valid_a = 1'b1;
        wait_ready(0);
        exp_qa.push_back(v[1].exp_frame);
        @(posedge clk);
        #1;
        wait_done(0, cyc);
        chk_i("b2b_first_latency", cyc, LEN_A);
        chk_i("b2b_ready_in_done", rdy(0), 1);
        exp_qa.push_back(v[1].exp_frame);
        @(negedge clk);
        #1;
        chk_i("b2b_gap_cycles", last_run_a, GAP_A);
        check_rx(0);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        chk_i("b2b_second_accept", bsy(0), 1);
        chk_i("b2b_done_one_cycle", dn(0), 0);
        wait_done(0, cyc);
        chk_i("b2b_second_latency", cyc, LEN_A);
        @(negedge clk);
        #1;
        check_rx(0);

        // Abort mid-frame at bit 100.
        @(negedge clk);
        drive(v[0].f);
        valid_a = 1'b1;
        wait_ready(0);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        t0 = 0;
        while (bits_a < 100 && t0 < 2000) begin
            @(negedge clk);
            t0++;
        end
        chk_i("abort_reached_bit100", bits_a, 100);
        d0 = done_cnt_a;
        n0 = rxn_a;
        #2;
        rst_n = 1'b0;
        #1;
        chk_i("abort_outputs", {29'b0, sclk_a, busy_a, done_a}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (900) @(negedge clk);
        chk_i("abort_no_done", done_cnt_a - d0, 0);
        chk_i("abort_no_rx_frame", rxn_a - n0, 0);
        run_frame(0, v[1].f, v[1].exp_frame, LEN_A);

`ifdef SERIAL_ENCODE_CKSUM_EN
        f = v[0].f;
        f.tl3 = 8'h00;
        run_frame(0, f, build_frame(f), LEN_A);
        chk_i("cksum_tail_3", {24'b0, last_rx[7:0]}, 32'h0000_00E3);
`else
        f = v[0].f;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
